// File: rtl/equiv_miter_monitor.sv
// Equivalence miter: compares y_a (delayed SKEW cycles) against y_b with warm-up blanking,
// sticky failure, saturating statistics and first-mismatch capture. Optional: EQUIV_MITER_ASSERT_EN.
module equiv_miter_monitor #(
  parameter int WIDTH  = 91,
  parameter int SKEW   = 0,
  parameter int WARMUP = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  output logic             mismatch,
  output logic             fail,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cmp_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_cycle,
  output logic [WIDTH-1:0] first_diff
);

  typedef enum logic [1:0] {
    ST_WARM   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_FAILED = 2'b10
  } state_t;

  localparam int WW = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam logic [WW-1:0] WARM_LAST = (WARMUP == 0) ? '0 : WW'(WARMUP - 1);

  state_t             state_q;
  logic               mismatch_q;
  logic               fail_q;
  logic [CNT_W-1:0]   cmp_count_q;
  logic [CNT_W-1:0]   err_count_q;
  logic [CNT_W-1:0]   first_cycle_q;
  logic [WIDTH-1:0]   first_diff_q;
  logic [WW-1:0]      warm_q;

  logic [WIDTH-1:0]   a_al;
  logic               cmp_en;
  logic               diff;
  logic [CNT_W-1:0]   cmp_count_d;
  logic [CNT_W-1:0]   err_count_d;

  generate
    if (SKEW == 0) begin : g_noskew
      assign a_al = y_a;
    end else begin : g_skew
      logic [SKEW-1:0][WIDTH-1:0] dly_q;
      // Shifts unconditionally so alignment is independent of in_valid.
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_q <= '0;
        end else begin
          dly_q[0] <= y_a;
          for (int i = 1; i < SKEW; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end
      assign a_al = dly_q[SKEW-1];
    end
  endgenerate

  // Case inequality so that X/Z on either side counts as a miscompare.
  assign diff   = (a_al !== y_b);
  assign cmp_en = in_valid && (state_q != ST_WARM);

  always_comb begin
    cmp_count_d = (cmp_count_q == '1) ? cmp_count_q : cmp_count_q + CNT_W'(1);
    err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WARM;
      mismatch_q    <= 1'b0;
      fail_q        <= 1'b0;
      cmp_count_q   <= '0;
      err_count_q   <= '0;
      first_cycle_q <= '0;
      first_diff_q  <= '0;
      warm_q        <= '0;
    end else begin
      mismatch_q <= cmp_en && diff;
      if (cmp_en) begin
        cmp_count_q <= cmp_count_d;
        if (diff) begin
          err_count_q <= err_count_d;
          fail_q      <= 1'b1;
          if (!fail_q) begin
            first_cycle_q <= cmp_count_q;
            first_diff_q  <= a_al ^ y_b;
          end
        end
      end
      case (state_q)
        ST_WARM: begin
          warm_q <= warm_q + WW'(1);
          if (WARMUP == 0 || warm_q == WARM_LAST) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (cmp_en && diff) begin
            state_q <= ST_FAILED;
          end
        end
        default: state_q <= ST_FAILED;
      endcase
    end
  end

`ifdef EQUIV_MITER_ASSERT_EN
  always @(posedge clk) begin
    if (!rst && cmp_en) begin
      assert (a_al === y_b);
    end
  end
`endif

  assign mismatch    = mismatch_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign cmp_count   = cmp_count_q;
  assign err_count   = err_count_q;
  assign first_cycle = first_cycle_q;
  assign first_diff  = first_diff_q;

endmodule

// File: doc/equiv_miter_monitor.md
Name: equiv_miter_monitor

Overview:
- Parametrised successor to the two-instance equivalence miter used in the fuzz/equivalence flow.
- Compares two implementations' output buses cycle by cycle and tolerates a fixed latency skew between them.
- Adds a warm-up blanking window, sticky failure state, saturating statistics and first-mismatch capture, so long fuzz runs report where and how they diverged, not just that an assertion fired.
- Sits at the top of each fuzz harness, between the DUT pair and the simulation/formal checker.

Parameters:
- WIDTH, 91, compared bus width in bits (default matches the current fuzz output bus).
- SKEW, 0, cycles by which y_b lags y_a; legal range 0..15.
- WARMUP, 4, cycles after reset release during which comparisons are ignored; must be >= SKEW.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies the current y_b sample and its aligned y_a sample.
- y_a  input  WIDTH  output of implementation A.
- y_b  input  WIDTH  output of implementation B.
- mismatch  output  1  one-cycle pulse, registered result of an enabled miscompare.
- fail  output  1  sticky, high once any enabled miscompare has occurred.
- state  output  2  00 WARM, 01 CHECK, 10 FAILED.
- cmp_count  output  CNT_W  enabled comparisons performed (saturating).
- err_count  output  CNT_W  enabled miscompares (saturating).
- first_cycle  output  CNT_W  cmp_count value at the first miscompare.
- first_diff  output  WIDTH  XOR of a and b at the first miscompare.

Behaviour:
- All ports are sampled and updated on the rising edge of clk. rst has priority over all other activity.
- Reset: state=WARM; mismatch=0, fail=0; all counters=0; first_cycle=0; first_diff=0; skew delay line cleared to 0; warm-up counter=0.
- Alignment:
  - y_a passes through a SKEW-stage register delay line, giving a_al. With SKEW=0, a_al = y_a combinationally.
  - y_b is used undelayed.
- Compare enable: cmp_en = in_valid && state != WARM.
- State machine:
  - WARM: warm-up counter increments each cycle. At the edge where the counter reaches WARMUP-1, state becomes CHECK. With WARMUP=0, CHECK is entered on the first cycle after reset.
  - CHECK: on an edge where cmp_en && (a_al != y_b), state becomes FAILED.
  - FAILED: terminal until rst. Comparisons and counting continue.
- Outputs, for the edge where cmp_en is true:
  - cmp_count increments.
  - If a_al != y_b: mismatch=1 in the following cycle, err_count increments, fail=1.
  - If this is the first miscompare since reset (fail was 0): first_cycle and first_diff are loaded.
  - mismatch is 0 on every other cycle.
- Capture rule: first_cycle holds the pre-increment cmp_count, i.e. 0-based comparison index. first_diff holds a_al ^ y_b.
- Saturation: counters stop at all-ones and do not wrap. err_count <= cmp_count always holds.
- in_valid low: no compare, no counter change. The delay line still shifts every cycle.
- Reset mid-run: clears everything, including FAILED, on that edge. The delay line must refill, and WARMUP >= SKEW guarantees that stale data is never compared.
- X/Z on either input: treated as a miscompare, using case inequality (!==).

Optional Feature:
- Macro: EQUIV_MITER_ASSERT_EN.
- Defined: an immediate assertion at posedge clk checks that cmp_en implies a_al === y_b, giving an assert-based failure usable by formal equivalence tools. All registered outputs remain present.
- Undefined: no assertion is compiled. Failure is reported only through fail, mismatch and the counters. Registered behaviour is identical in both builds.

Test Plan:
- Reset release, WARMUP=4, SKEW=0, in_valid=1, y_a=y_b=0x1234: state reaches CHECK after 4 cycles. After 10 further cycles cmp_count=10, err_count=0, fail=0.
- SKEW=3, y_b = y_a delayed by 3 cycles, random data for 100 cycles: err_count=0, fail=0.
- SKEW=0, in CHECK, inject y_b = y_a ^ (1<<90) on the 6th comparison: mismatch pulses one cycle later, fail=1, state=FAILED, first_cycle=5, first_diff has only bit 90 set.
- After the first failure, inject two further diffs with different masks: err_count=3, first_cycle and first_diff unchanged.
- Miscompare during WARM: no effect, err_count=0. Then assert rst for one cycle while in FAILED: all outputs return to reset values and state=WARM.
- CNT_W=4, 20 mismatching valid cycles: cmp_count=15, err_count=15, with no wrap.
